// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive FSM and its surrounding logic.
// The BREAK output exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_fsm_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  SAMPLED_BIT;
  logic                  DAT_SAMP_EN;
  logic [5:0]            EDGE_CNT;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
`ifdef UART_RX_BREAK_DET_EN
  logic                  BREAK;
`endif

  modport master (
`ifdef UART_RX_BREAK_DET_EN
    input  BREAK,
`endif
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, SAMPLED_BIT,
    input  DAT_SAMP_EN, EDGE_CNT, P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
`ifdef UART_RX_BREAK_DET_EN
    output BREAK,
`endif
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, SAMPLED_BIT,
    output DAT_SAMP_EN, EDGE_CNT, P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: start/data/parity/stop sequencing over an oversampled line.
// Optional break detection enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input logic         CLK,
  input logic         RST,
  uart_rx_fsm_if.slave bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [5:0]            presc_q, presc_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic                  bit_end, par_mis;
`ifdef UART_RX_BREAK_DET_EN
  logic                  zero_q, zero_d, hold_q, hold_d, brk_q, brk_d, pdef_q, pdef_d;
`endif

  assign bit_end = (edge_cnt_q == presc_q - 6'd1);
  assign par_mis = bus.SAMPLED_BIT != (^p_data_q ^ par_typ_q);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = (state_q == IDLE) ? 6'd0 : (bit_end ? 6'd0 : edge_cnt_q + 6'd1);
    presc_d    = presc_q;
    bit_cnt_d  = bit_cnt_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_d     = zero_q;
    hold_d     = hold_q;
    brk_d      = 1'b0;
    pdef_d     = pdef_q;
`endif
    case (state_q)
      IDLE: begin
        // Line config is captured only here, so it stays fixed for the whole frame.
        presc_d   = bus.PRESCALE;
        par_en_d  = bus.PAR_EN;
        par_typ_d = bus.PAR_TYP;
        bit_cnt_d = '0;
        par_bad_d = 1'b0;
        if (!bus.RX_IN) state_d = START;
      end
      START: begin
`ifdef UART_RX_BREAK_DET_EN
        zero_d = 1'b1;
        pdef_d = 1'b0;
`endif
        if (bit_end) state_d = bus.SAMPLED_BIT ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        p_data_d = {bus.SAMPLED_BIT, p_data_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
        zero_d = zero_q & ~bus.SAMPLED_BIT;
`endif
        if (bit_cnt_q == BW'(DATA_WIDTH-1)) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        par_bad_d = par_mis;
        state_d   = STOP;
`ifdef UART_RX_BREAK_DET_EN
        // A still-all-zero frame may turn out to be a break; defer its parity verdict.
        zero_d = zero_q & ~bus.SAMPLED_BIT;
        if (zero_q && !bus.SAMPLED_BIT) pdef_d = par_mis;
        else                            pe_d   = par_mis;
`else
        pe_d = par_mis;
`endif
      end
      STOP: begin
`ifdef UART_RX_BREAK_DET_EN
        if (hold_q) begin
          if (bus.RX_IN) begin
            hold_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (bit_end) begin
          if (zero_q && !bus.SAMPLED_BIT) begin
            brk_d  = 1'b1;
            hold_d = 1'b1;
          end else begin
            se_d    = ~bus.SAMPLED_BIT;
            dv_d    = bus.SAMPLED_BIT & ~par_bad_q;
            pe_d    = pdef_q & bus.SAMPLED_BIT;
            state_d = IDLE;
          end
        end
`else
        if (bit_end) begin
          se_d    = ~bus.SAMPLED_BIT;
          dv_d    = bus.SAMPLED_BIT & ~par_bad_q;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= 6'd8;
      bit_cnt_q  <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q     <= 1'b0;
      hold_q     <= 1'b0;
      brk_q      <= 1'b0;
      pdef_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      presc_q    <= presc_d;
      bit_cnt_q  <= bit_cnt_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q     <= zero_d;
      hold_q     <= hold_d;
      brk_q      <= brk_d;
      pdef_q     <= pdef_d;
`endif
    end
  end

  assign bus.EDGE_CNT   = edge_cnt_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.PAR_ERR    = pe_q;
  assign bus.STP_ERR    = se_q;
`ifdef UART_RX_BREAK_DET_EN
  assign bus.BREAK       = brk_q;
  assign bus.DAT_SAMP_EN = (state_q != IDLE) && !hold_q;
`else
  assign bus.DAT_SAMP_EN = (state_q != IDLE);
`endif
endmodule
